// File: rtl/led_line_encoder.sv
// Debounces the four decoded LED lines and re-encodes them into the 2-bit switch code.
// Build option: LED_ENC_STICKY_ERR_EN makes err sticky until reset or an all-zero accept.
module led_line_encoder #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       led0,
   input  logic       led1,
   input  logic       led2,
   input  logic       led3,
   output logic       sw0,
   output logic       sw1,
   output logic       valid,
   output logic       err,
   output logic       strobe,
   output logic [1:0] dbg_state
);

   // Encoding of dbg_state: 0 = IDLE, 1 = ACTIVE, 2 = FAULT.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FAULT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [3:0]       led_in;
   logic [3:0]       sync1_q;
   logic [3:0]       s_q;
   logic [3:0]       p_q;
   logic [3:0]       acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             accept;
   logic             multi_hot;
   logic             one_hot;
   logic [1:0]       hi_idx;
   state_t           state_q;
   state_t           state_d;
   logic [1:0]       sw_q;
   logic             valid_q;
   logic             err_q;
   logic             strobe_q;

   assign led_in = {led3, led2, led1, led0};

   always_comb begin
      cnt_d = cnt_q;
      if (s_q != p_q) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end
      accept = (s_q == p_q) && (cnt_q == CNT_MAX);

      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_hot = |(s_q & (s_q - 4'd1));
      one_hot   = (s_q != 4'd0) && !multi_hot;

      hi_idx = 2'd0;
      if (s_q[3]) begin
         hi_idx = 2'd3;
      end else if (s_q[2]) begin
         hi_idx = 2'd2;
      end else if (s_q[1]) begin
         hi_idx = 2'd1;
      end

      state_d = IDLE;
      if (multi_hot) begin
         state_d = FAULT;
      end else if (one_hot) begin
         state_d = ACTIVE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         s_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= led_in;
         s_q     <= sync1_q;
         p_q     <= s_q;
         cnt_q   <= cnt_d;
      end
   end

   // Accepted-pattern FSM; all outputs are registered on the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         state_q  <= IDLE;
         sw_q     <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (accept) begin
            acc_q    <= s_q;
            strobe_q <= (s_q != acc_q);
            state_q  <= state_d;
            case (state_d)
               ACTIVE: begin
                  valid_q <= 1'b1;
                  sw_q    <= hi_idx;
`ifdef LED_ENC_STICKY_ERR_EN
                  err_q   <= err_q;
`else
                  err_q   <= 1'b0;
`endif
               end
               FAULT: begin
                  valid_q <= 1'b0;
                  err_q   <= 1'b1;
                  sw_q    <= hi_idx;
               end
               default: begin
                  valid_q <= 1'b0;
                  err_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sw0       = sw_q[0];
   assign sw1       = sw_q[1];
   assign valid     = valid_q;
   assign err       = err_q;
   assign strobe    = strobe_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_led_line_encoder.sv
// Directed bench for led_line_encoder: default instance (STABLE_CYCLES=4) plus a
// minimum-window instance (STABLE_CYCLES=1) sharing clock and reset.
module tb_led_line_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] led;
   logic [3:0] led_m;

   logic       sw0, sw1, valid, err, strobe;
   logic [1:0] dbg_state;
   logic       sw0_m, sw1_m, valid_m, err_m, strobe_m;
   logic [1:0] dbg_state_m;

   logic [4:0] obs;
   logic [4:0] obs_m;
   logic [3:0] cur;
   logic       sticky;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign obs   = {sw1, sw0, valid, err, strobe};
   assign obs_m = {sw1_m, sw0_m, valid_m, err_m, strobe_m};

   led_line_encoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .led0(led[0]), .led1(led[1]), .led2(led[2]), .led3(led[3]),
      .sw0(sw0), .sw1(sw1), .valid(valid), .err(err), .strobe(strobe),
      .dbg_state(dbg_state)
   );

   led_line_encoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut_min (
      .clk(clk), .rst_n(rst_n),
      .led0(led_m[0]), .led1(led_m[1]), .led2(led_m[2]), .led3(led_m[3]),
      .sw0(sw0_m), .sw1(sw1_m), .valid(valid_m), .err(err_m), .strobe(strobe_m),
      .dbg_state(dbg_state_m)
   );

   // Drives a pattern and checks every edge: old outputs for 6 edges, the new
   // outputs plus strobe on edge 7, then steady new outputs with no strobe.
   task automatic apply_pattern(input logic [3:0] pat, input logic [3:0] nxt,
                                input logic stb, input int hold, input string name);
      logic [4:0] exp;
      @(posedge clk); #1;
      led = pat;
      for (int k = 1; k <= hold; k++) begin
         @(posedge clk); #1;
         if (k < 7)       exp = {cur, 1'b0};
         else if (k == 7) exp = {nxt, stb};
         else             exp = {nxt, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %b expected %b", name, k, obs, exp);
         end
      end
      cur = nxt;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      led   = 4'b0000;
      led_m = 4'b0000;
      cur   = 4'b0000;
      #2;
      n_cmp++;
      if ({obs, obs_m} !== 10'd0) begin
         n_err++;
         $display("FAIL reset_init: got %b/%b expected 00000/00000", obs, obs_m);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (obs !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_idle edge %0d: got %b expected 00000", k, obs);
         end
      end
   endtask

   task automatic test_decode_sweep;
      apply_pattern(4'b0001, {2'b00, 1'b1, 1'b0}, 1'b1, 10, "sweep_0001");
      apply_pattern(4'b0010, {2'b01, 1'b1, 1'b0}, 1'b1, 10, "sweep_0010");
      apply_pattern(4'b0100, {2'b10, 1'b1, 1'b0}, 1'b1, 10, "sweep_0100");
      apply_pattern(4'b1000, {2'b11, 1'b1, 1'b0}, 1'b1, 10, "sweep_1000");
   endtask

   task automatic test_glitch;
      logic [4:0] exp;
      apply_pattern(4'b0001, {2'b00, 1'b1, 1'b0}, 1'b1, 10, "glitch_setup");
      // 3-cycle pulse: must be rejected entirely.
      @(posedge clk); #1;
      led = 4'b0010;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (k == 3) led = 4'b0001;
         n_cmp++;
         if (obs !== 5'b00100) begin
            n_err++;
            $display("FAIL glitch3 edge %0d: got %b expected 00100", k, obs);
         end
      end
      // 5-cycle pulse: accepted on edge 7, and the return to 0001 on edge 12.
      @(posedge clk); #1;
      led = 4'b0010;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         if (k == 5) led = 4'b0001;
         if (k < 7)        exp = 5'b00100;
         else if (k == 7)  exp = 5'b01101;
         else if (k < 12)  exp = 5'b01100;
         else if (k == 12) exp = 5'b00101;
         else              exp = 5'b00100;
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL glitch5 edge %0d: got %b expected %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_fault;
      apply_pattern(4'b0110, {2'b10, 1'b0, 1'b1},   1'b1, 10, "fault_0110");
      apply_pattern(4'b0001, {2'b00, 1'b1, sticky}, 1'b1, 10, "fault_then_0001");
      apply_pattern(4'b0000, {2'b00, 1'b0, 1'b0},   1'b1, 10, "fault_clear_0000");
   endtask

   task automatic test_repeat_idle;
      apply_pattern(4'b1000, {2'b11, 1'b1, 1'b0}, 1'b1, 10,  "repeat_1000_a");
      apply_pattern(4'b0000, {2'b11, 1'b0, 1'b0}, 1'b1, 10,  "repeat_idle");
      apply_pattern(4'b1000, {2'b11, 1'b1, 1'b0}, 1'b1, 100, "repeat_1000_hold");
   endtask

   task automatic test_reset_mid;
      logic [4:0] exp;
      apply_pattern(4'b0100, {2'b10, 1'b1, 1'b0}, 1'b1, 10, "rst_setup_0100");
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_async: got %b expected 00000", obs);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_held: got %b expected 00000", obs);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k < 7)       exp = 5'b00000;
         else if (k == 7) exp = 5'b10101;
         else             exp = 5'b10100;
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_release edge %0d: got %b expected %b", k, obs, exp);
         end
      end
      cur = 4'b1010;
   endtask

   task automatic test_min_window;
      logic [4:0] exp;
      @(posedge clk); #1;
      led_m = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k < 4)       exp = 5'b00000;
         else if (k == 4) exp = 5'b00101;
         else             exp = 5'b00100;
         n_cmp++;
         if (obs_m !== exp) begin
            n_err++;
            $display("FAIL min_0001 edge %0d: got %b expected %b", k, obs_m, exp);
         end
      end
      @(posedge clk); #1;
      led_m = 4'b0100;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k < 4)       exp = 5'b00100;
         else if (k == 4) exp = 5'b10101;
         else             exp = 5'b10100;
         n_cmp++;
         if (obs_m !== exp) begin
            n_err++;
            $display("FAIL min_0100 edge %0d: got %b expected %b", k, obs_m, exp);
         end
      end
   endtask

   initial begin
`ifdef LED_ENC_STICKY_ERR_EN
      sticky = 1'b1;
`else
      sticky = 1'b0;
`endif
      test_reset();
      test_decode_sweep();
      test_glitch();
      test_fault();
      test_repeat_idle();
      test_reset_mid();
      test_min_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/led_line_encoder.md
# led_line_encoder

- Reverse-direction companion to the board's 2-to-4 switch decoder: samples the four decoded LED lines, debounces them and re-encodes them into the 2-bit switch code.
- Flags an invalid (multi-hot) pattern and pulses a strobe on every newly accepted pattern.
- Sits on the loop-back/readback path so the decoder output can be checked on hardware against the switches that drove it.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive clocks a synchronized pattern must stay unchanged before acceptance; legal 1..255
- CNT_W, 8, stability counter width; must hold STABLE_CYCLES-1

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- led0, led1, led2, led3  input  1 each  decoded lines, asynchronous to clk; led0 = index 0
- sw0  output  1  code bit 0 of accepted pattern
- sw1  output  1  code bit 1 of accepted pattern
- valid  output  1  accepted pattern is exactly one-hot
- err  output  1  accepted pattern has two or more lines set
- strobe  output  1  one-cycle pulse when the accepted pattern changes

## Operation
- **Synchronizer.** Two flops per line produce vector s[3:0]. A third register p holds s delayed by one clock.
- **Stability counter (cnt).**
  - s != p: cnt <= 0.
  - s == p and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - Otherwise cnt holds (saturates at STABLE_CYCLES-1).
- **Accept.** At an edge where s == p and cnt == STABLE_CYCLES-1, acc <= s.
- **FSM.** Outputs are registered and updated on that same edge. The FSM state follows the newly accepted vector:
  - IDLE: acc == 0. valid=0, err=0, sw1/sw0 hold their previous values.
  - ACTIVE: acc one-hot. valid=1, err=0, {sw1,sw0} = index of the set bit (0001->00, 0010->01, 0100->10, 1000->11).
  - FAULT: two or more bits set. valid=0, err=1, {sw1,sw0} = index of the highest set bit.
  - Every transition IDLE/ACTIVE/FAULT <-> any state is legal in one accept.
- **Strobe.** strobe=1 for exactly one clock when the newly loaded acc differs from the old acc. Re-accepting an identical vector gives no strobe.
- **Glitch rejection.** A pattern that holds for fewer than STABLE_CYCLES+1 synchronized samples is never accepted; acc, outputs and state are unchanged.
- **Reset.** rst_n low clears immediately, regardless of clock: sync flops, p, cnt, acc = 0, state IDLE, sw0=0, sw1=0, valid=0, err=0, strobe=0. After release, a pattern needs the full latency again. No strobe is generated for the post-reset all-zero state.

## Timing
- **Latency.** An input change set up before edge E appears on the outputs at edge E+STABLE_CYCLES+2, i.e. STABLE_CYCLES+3 edges counting E. With the default of 4 that is 7 edges.
- **Strobe timing.** strobe rises on the same edge as the output update and falls on the next edge.
- **Pattern change during counting.** cnt returns to 0 on the first edge where s != p. Latency restarts from the new pattern; the old outputs hold.
- **Reset mid-count.** All progress is lost; outputs read reset values until a full latency elapses after release.
- **Minimum stable window.** STABLE_CYCLES=1 gives acceptance after two equal consecutive samples (latency 4).
- **Back-to-back patterns.** Each held for at least the latency, each produces exactly one strobe.

## Configuration
- Macro: LED_ENC_STICKY_ERR_EN.
- **Defined:** err is sticky. Once set by a FAULT accept, it stays 1 through later ACTIVE accepts. It is cleared only by rst_n low or by an accept of the all-zero pattern. valid and sw behave as normal.
- **Undefined:** err follows the current state (1 only in FAULT).

## Test plan
- **Reset.** Assert rst_n=0 mid-simulation with led=0100 stable -> sw1=0, sw0=0, valid=0, err=0, strobe=0 immediately. Release -> sw=10, valid=1 exactly 7 edges later with one strobe pulse.
- **Full decode sweep.** STABLE_CYCLES=4, drive 0001, 0010, 0100, 1000, each held 10 cycles -> sw={00,01,10,11}, valid=1, err=0, four strobes, each 7 edges after its change.
- **Glitch.** With led=0001 accepted, pulse led=0010 for 3 cycles then return -> no output change, no strobe. A 5-cycle pulse is accepted (sw=01, strobe).
- **Fault.** Drive 0110 -> err=1, valid=0, sw=10. Then 0001 -> err=0 without the macro, err=1 with LED_ENC_STICKY_ERR_EN. Then 0000 -> err=0, valid=0 in both builds.
- **Repeat and idle.** Drive 1000, then 0000, then 1000 -> three strobes. In IDLE, sw holds 11 and valid=0. Holding 1000 for 100 cycles produces no extra strobe.
- **Minimum window.** Set STABLE_CYCLES=1, step led 0001->0100 -> outputs update 4 edges after the change.
